planificador_comida: RTL and testbench



---
 rtl/planificador_comida_pkg.sv | 28 ++
 rtl/planificador_comida_contador_tick.sv | 26 ++
 rtl/planificador_comida.sv | 113 +++++++++++
 tb/tb_planificador_comida.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/planificador_comida_pkg.sv
// Shared definitions for the pet controller: arbiter state codes and food level codes.
package pkg_mascota;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      ALIMENTANDO = 2'b01,
      MEDICANDO   = 2'b10,
      ENFRIANDO   = 2'b11
   } estado_t;

   // Food level codes, also consumed by the pet state machine
   localparam logic [1:0] NIVEL_VACIO = 2'd0;
   localparam logic [1:0] NIVEL_BAJO  = 2'd1;
   localparam logic [1:0] NIVEL_MEDIO = 2'd2;
   localparam logic [1:0] NIVEL_LLENO = 2'd3;

   localparam logic [1:0] NIVEL_MAX = NIVEL_LLENO;
   localparam logic [1:0] NIVEL_MIN = NIVEL_VACIO;

   // Clamp a 3-bit intermediate level back into the 2-bit level range
   function automatic logic [1:0] saturar_nivel(input logic [2:0] valor);
      if (valor > {1'b0, NIVEL_MAX})
         return NIVEL_MAX;
      else
         return valor[1:0];
   endfunction

endpackage

// File: rtl/planificador_comida_contador_tick.sv
// Modulo-N counter with enable and clear; tc is high on the enabled cycle that wraps.
module contador_tick #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] ULTIMO = W'(N - 1);

   logic [W-1:0] cnt;

   assign tc = en && (cnt == ULTIMO);

   // Count while enabled, wrap to zero at the terminal count; clear wins over enable
   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (en)
         cnt <= tc ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/planificador_comida.sv
// Food level controller: hunger decay, held-button feeding and food/medicine arbitration.
module planificador_comida
   import pkg_mascota::*;
#(
   parameter int DECAY_TICKS    = 50_000_000,
   parameter int FEED_TICKS     = 25_000_000,
   parameter int COOLDOWN_TICKS = 12_500_000,
   parameter int NIVEL_INICIAL  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Boton_Comida,
   input  logic       Boton_Medicina,
   input  logic       Sensor_Luz,
   input  logic       Activo_Comida,
   input  logic       Activo_Medicina,
   output logic [1:0] Nivel_Comida,
   output logic       Medicina_Ok,
   output logic       Alerta_Desnutricion,
   output logic [1:0] Estado_Ctrl,
   output logic       Ocupado
);

   estado_t estado, estado_sig;
   logic    decay_tc, feed_tc, cool_tc;
   logic    decay_en, feed_en, feed_clr, cool_en;
   logic    pide_comida, pide_medicina;

   assign pide_comida   = Boton_Comida & Activo_Comida;
   assign pide_medicina = Boton_Medicina & Activo_Medicina;

   // Decay is frozen while feeding, so a feed step and a decay step never coincide
   assign decay_en = Sensor_Luz && (estado != ALIMENTANDO);
   assign feed_en  = (estado == ALIMENTANDO) && Boton_Comida;
   // Releasing the button discards any partial hold
   assign feed_clr = reset || ((estado == ALIMENTANDO) && !Boton_Comida);
   assign cool_en  = (estado == ENFRIANDO);

   contador_tick #(.N(DECAY_TICKS)) u_decay (
      .clk (clk),
      .clr (reset),
      .en  (decay_en),
      .tc  (decay_tc)
   );

   contador_tick #(.N(FEED_TICKS)) u_feed (
      .clk (clk),
      .clr (feed_clr),
      .en  (feed_en),
      .tc  (feed_tc)
   );

   contador_tick #(.N(COOLDOWN_TICKS)) u_cool (
      .clk (clk),
      .clr (reset),
      .en  (cool_en),
      .tc  (cool_tc)
   );

   // Arbiter state register
   always_ff @(posedge clk) begin
      if (reset)
         estado <= IDLE;
      else
         estado <= estado_sig;
   end

   // Arbiter next state: food wins over medicine, buttons only matter in IDLE
   always_comb begin
      estado_sig = estado;
      case (estado)
         IDLE: begin
            if (pide_comida)
               estado_sig = ALIMENTANDO;
            else if (pide_medicina)
               estado_sig = MEDICANDO;
         end
         ALIMENTANDO: begin
            if (!Boton_Comida)
               estado_sig = ENFRIANDO;
         end
         MEDICANDO: estado_sig = ENFRIANDO;
         ENFRIANDO: begin
            if (cool_tc)
               estado_sig = IDLE;
         end
         default: estado_sig = IDLE;
      endcase
   end

   // Food level: +1 per completed hold (saturating at 3), -1 per decay tick (floored at 0)
   always_ff @(posedge clk) begin
      if (reset)
         Nivel_Comida <= 2'(NIVEL_INICIAL);
      else if (feed_tc)
         Nivel_Comida <= saturar_nivel({1'b0, Nivel_Comida} + 3'd1);
      else if (decay_tc && (Nivel_Comida != NIVEL_MIN))
         Nivel_Comida <= Nivel_Comida - 2'd1;
   end

   // Starvation alert: a decay tick that finds the level already empty
   always_ff @(posedge clk) begin
      if (reset)
         Alerta_Desnutricion <= 1'b0;
      else
         Alerta_Desnutricion <= decay_tc && (Nivel_Comida == NIVEL_MIN);
   end

   assign Medicina_Ok = (estado == MEDICANDO);
   assign Estado_Ctrl = estado;
   assign Ocupado     = (estado != IDLE);

endmodule

// File: tb/tb_planificador_comida.sv
// Scoreboard bench: stimulus task pushes model predictions, negedge monitor compares.
module tb_planificador_comida;

   localparam int D = 8;
   localparam int F = 4;
   localparam int C = 3;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       reset, bc, bm, luz, ac, am;
   logic [1:0] Nivel_Comida, Estado_Ctrl;
   logic       Medicina_Ok, Alerta_Desnutricion, Ocupado;

   planificador_comida #(
      .DECAY_TICKS(D), .FEED_TICKS(F), .COOLDOWN_TICKS(C), .NIVEL_INICIAL(NI)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .Boton_Comida        (bc),
      .Boton_Medicina      (bm),
      .Sensor_Luz          (luz),
      .Activo_Comida       (ac),
      .Activo_Medicina     (am),
      .Nivel_Comida        (Nivel_Comida),
      .Medicina_Ok         (Medicina_Ok),
      .Alerta_Desnutricion (Alerta_Desnutricion),
      .Estado_Ctrl         (Estado_Ctrl),
      .Ocupado             (Ocupado)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int lvl;
      int med;
      int alr;
      int ocu;
      int cyc;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Reference state: mode 0 idle, 1 feeding, 2 medicine, 3 cooldown
   int m_mode, m_lvl, m_since_decay, m_held, m_cool, m_alert;

   task automatic model(input bit r, input bit b_c, input bit b_m, input bit l,
                        input bit a_c, input bit a_m);
      int new_lvl;
      int new_mode;
      if (r) begin
         m_mode = 0; m_lvl = NI; m_since_decay = 0; m_held = 0; m_cool = 0; m_alert = 0;
         return;
      end
      new_lvl  = m_lvl;
      new_mode = m_mode;
      m_alert  = 0;
      if (l && m_mode != 1) begin
         m_since_decay++;
         if (m_since_decay == D) begin
            m_since_decay = 0;
            if (m_lvl > 0) new_lvl = m_lvl - 1;
            else m_alert = 1;
         end
      end
      case (m_mode)
         0: if (b_c && a_c) new_mode = 1;
            else if (b_m && a_m) new_mode = 2;
         1: if (b_c) begin
               m_held++;
               if (m_held == F) begin
                  m_held = 0;
                  new_lvl = (m_lvl + 1 > 3) ? 3 : m_lvl + 1;
               end
            end else begin
               m_held = 0;
               new_mode = 3;
            end
         2: new_mode = 3;
         default: begin
            m_cool++;
            if (m_cool == C) begin
               m_cool = 0;
               new_mode = 0;
            end
         end
      endcase
      m_lvl  = new_lvl;
      m_mode = new_mode;
   endtask

   task automatic step(input bit r, input bit b_c, input bit b_m, input bit l,
                       input bit a_c, input bit a_m);
      exp_t e;
      reset = r; bc = b_c; bm = b_m; luz = l; ac = a_c; am = a_m;
      @(posedge clk);
      #1;
      cyc++;
      model(r, b_c, b_m, l, a_c, a_m);
      e.st  = m_mode;
      e.lvl = m_lvl;
      e.med = (m_mode == 2) ? 1 : 0;
      e.alr = m_alert;
      e.ocu = (m_mode != 0) ? 1 : 0;
      e.cyc = cyc;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input int c, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle, so pop one prediction per falling edge
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("estado",  e.cyc, int'(Estado_Ctrl), e.st);
         chk("nivel",   e.cyc, int'(Nivel_Comida), e.lvl);
         chk("medicina", e.cyc, int'(Medicina_Ok), e.med);
         chk("alerta",  e.cyc, int'(Alerta_Desnutricion), e.alr);
         chk("ocupado", e.cyc, int'(Ocupado), e.ocu);
      end
   end

   initial begin
      reset = 1'b1; bc = 1'b0; bm = 1'b0; luz = 1'b1; ac = 1'b1; am = 1'b1;
      m_mode = 0; m_lvl = NI; m_since_decay = 0; m_held = 0; m_cool = 0; m_alert = 0;

      // Reset, then free-running decay past empty
      repeat (2) step(1, 0, 0, 1, 1, 1);
      repeat (36) step(0, 0, 0, 1, 1, 1);
      // Long feed hold, release into cooldown
      repeat (9) step(0, 1, 0, 1, 1, 0);
      repeat (5) step(0, 0, 0, 1, 1, 1);
      // Both buttons: food wins
      step(0, 1, 1, 1, 1, 1);
      repeat (5) step(0, 0, 0, 1, 1, 1);
      // Medicine granted, then refused
      step(0, 0, 1, 1, 1, 1);
      repeat (5) step(0, 0, 0, 1, 1, 1);
      repeat (3) step(0, 0, 1, 1, 1, 0);
      // Darkness pauses decay, light resumes it
      repeat (2) step(1, 0, 0, 1, 1, 1);
      repeat (3) step(0, 0, 0, 1, 1, 1);
      repeat (20) step(0, 0, 0, 0, 1, 1);
      repeat (20) step(0, 0, 0, 1, 1, 1);
      // Reset while feeding
      repeat (12) step(0, 0, 0, 1, 1, 1);
      repeat (3) step(0, 1, 0, 1, 1, 1);
      step(1, 1, 0, 1, 1, 1);
      repeat (4) step(0, 0, 0, 1, 1, 1);

      // Random bursts of held input patterns
      for (int k = 0; k < 300; k++) begin
         bit r_b, c_b, m_b, l_b, ac_b, am_b;
         int len;
         len  = $urandom_range(1, 12);
         c_b  = ($urandom_range(0, 2) != 0);
         m_b  = ($urandom_range(0, 1) != 0);
         l_b  = ($urandom_range(0, 4) != 0);
         ac_b = ($urandom_range(0, 3) != 0);
         am_b = ($urandom_range(0, 3) != 0);
         r_b  = ($urandom_range(0, 60) == 0);
         for (int j = 0; j < len; j++)
            step(r_b && (j == 0), c_b, m_b, l_b, ac_b, am_b);
      end

      @(negedge clk);
      #1;
      chk("cola_vacia", cyc, q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
